alu_operand_sequencer: RTL and testbench

- Multicycle control FSM that drives the operand-select inputs of the ALU B-input mux and ALU A-input mux, plus ALU operation and datapath write enables.
- Sits in the control unit, one level above the datapath muxes.
- Sequences fetch, decode, execute and writeback for a restricted instruction subset: R-type add/sub/and/addm, addi, beq.
- Reports illegal opcodes.

---
 rtl/alu_operand_sequencer.sv | 174 +++++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// Multicycle control FSM for a restricted MIPS-like subset (add/sub/and/addm/addi/beq).
// Drives ALU operand-select muxes, ALU operation and datapath write enables; flags illegal opcodes.
module alu_operand_sequencer #(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [2:0] ALUCtrl,
    output logic       MemRead,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MDRWrite,
    output logic       PCWrite,
    output logic       PCSource,
    output logic       ALUOutWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       illegal_op
);
    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_R_EXEC  = 4'd3,
        S_R_WB    = 4'd4,
        S_I_EXEC  = 4'd5,
        S_I_WB    = 4'd6,
        S_MEM_RD  = 4'd7,
        S_M_EXEC  = 4'd8,
        S_BEQ     = 4'd9,
        S_ILLEGAL = 4'd10
    } state_t;

    localparam logic [2:0] OP_IDLE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;

    localparam logic [2:0] SRCB_B    = 3'b000;
    localparam logic [2:0] SRCB_FOUR = 3'b001;
    localparam logic [2:0] SRCB_SHL2 = 3'b010;
    localparam logic [2:0] SRCB_SEXT = 3'b011;
    localparam logic [2:0] SRCB_MDR  = 3'b100;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] rop_q, rop_d;
    logic       wait_done;

    assign wait_done = (cnt_q == WAIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RST;
            cnt_q   <= 3'd0;
            rop_q   <= OP_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rop_q   <= rop_d;
        end
    end

    // Counter holds zero outside the memory states, so every entry into them starts at 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = 3'd0;
        rop_d   = rop_q;
        case (state_q)
            S_RST:   state_d = S_FETCH;
            S_FETCH: begin
                if (wait_done) state_d = S_DECODE;
                else           cnt_d   = cnt_q + 3'd1;
            end
            S_DECODE: begin
                case (opcode)
                    6'h00: begin
                        case (funct)
                            6'h20: begin state_d = S_R_EXEC; rop_d = OP_ADD; end
                            6'h22: begin state_d = S_R_EXEC; rop_d = OP_SUB; end
                            6'h24: begin state_d = S_R_EXEC; rop_d = OP_AND; end
                            6'h05: state_d = S_MEM_RD;
                            default: state_d = S_ILLEGAL;
                        endcase
                    end
                    6'h08:   state_d = S_I_EXEC;
                    6'h04:   state_d = S_BEQ;
                    default: state_d = S_ILLEGAL;
                endcase
            end
            S_R_EXEC: state_d = S_R_WB;
            S_I_EXEC: state_d = S_I_WB;
            S_MEM_RD: begin
                if (wait_done) state_d = S_M_EXEC;
                else           cnt_d   = cnt_q + 3'd1;
            end
            S_M_EXEC: state_d = S_R_WB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUCtrl     = OP_IDLE;
        MemRead     = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        MDRWrite    = 1'b0;
        PCWrite     = 1'b0;
        PCSource    = 1'b0;
        ALUOutWrite = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        illegal_op  = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ALUCtrl = OP_ADD;
                IRWrite = wait_done;
                PCWrite = wait_done;
            end
            S_DECODE: begin
                ALUSrcB     = SRCB_SHL2;
                ALUCtrl     = OP_ADD;
                ALUOutWrite = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA     = 1'b1;
                ALUCtrl     = rop_q;
                ALUOutWrite = 1'b1;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_I_EXEC: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_SEXT;
                ALUCtrl     = OP_ADD;
                ALUOutWrite = 1'b1;
            end
            S_I_WB: RegWrite = 1'b1;
            S_MEM_RD: begin
                MemRead  = 1'b1;
                IorD     = 1'b1;
                MDRWrite = wait_done;
            end
            S_M_EXEC: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_MDR;
                ALUCtrl     = OP_ADD;
                ALUOutWrite = 1'b1;
            end
            // Branch decision is the only Mealy path: PCWrite follows the live zero flag.
            S_BEQ: begin
                ALUSrcA  = 1'b1;
                ALUCtrl  = OP_SUB;
                PCSource = 1'b1;
                PCWrite  = zero;
            end
            S_ILLEGAL: illegal_op = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed per-cycle vector bench for alu_operand_sequencer (MEM_WAIT=2).
module tb_alu_operand_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       ALUSrcA;
    logic [2:0] ALUSrcB;
    logic [2:0] ALUCtrl;
    logic       MemRead, IorD, IRWrite, MDRWrite, PCWrite, PCSource;
    logic       ALUOutWrite, RegWrite, RegDst, illegal_op;

    alu_operand_sequencer #(.MEM_WAIT(2)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl),
        .MemRead(MemRead), .IorD(IorD), .IRWrite(IRWrite), .MDRWrite(MDRWrite),
        .PCWrite(PCWrite), .PCSource(PCSource), .ALUOutWrite(ALUOutWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;
    int   n_applied = 0;
    int   n_fail = 0;

    // Field order: SrcA, SrcB[3], Ctrl[3], MemRead, IorD, IRWrite, MDRWrite,
    // PCWrite, PCSource, ALUOutWrite, RegWrite, RegDst, illegal_op
    function automatic logic [17:0] mk(input logic a, input logic [2:0] b, input logic [2:0] c,
                                       input logic mr, input logic iord, input logic irw,
                                       input logic mdrw, input logic pcw, input logic pcs,
                                       input logic aow, input logic rw, input logic rd,
                                       input logic ill);
        return {a, b, c, mr, iord, irw, mdrw, pcw, pcs, aow, rw, rd, ill};
    endfunction

    logic [17:0] ZERO, F1, F2, DEC, RWB, IEX, IWB, MR1, MR2, MEX, BEQ_T, BEQ_N, ILL;

    task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input logic [17:0] e);
        vecs[nvec].op  = op;
        vecs[nvec].fn  = fn;
        vecs[nvec].z   = z;
        vecs[nvec].exp = e;
        nvec++;
    endtask

    task automatic push_front(input logic [5:0] op, input logic [5:0] fn);
        push(op, fn, 1'b1, F1);
        push(op, fn, 1'b1, F2);
        push(op, fn, 1'b1, DEC);
    endtask

    task automatic check(input string name, input logic [17:0] e);
        logic [17:0] got;
        got = {ALUSrcA, ALUSrcB, ALUCtrl, MemRead, IorD, IRWrite, MDRWrite,
               PCWrite, PCSource, ALUOutWrite, RegWrite, RegDst, illegal_op};
        n_applied++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s: outputs got %b required %b", name, got, e);
        end
        $display("%s op=%h fn=%h z=%b out=%b", name, opcode, funct, zero, got);
    endtask

    task automatic step(input string name, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic [17:0] e);
        @(negedge clk);
        opcode = op;
        funct  = fn;
        zero   = z;
        #1;
        check(name, e);
    endtask

    initial begin
        ZERO  = '0;
        F1    = mk(0, 3'b001, 3'b001, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        F2    = mk(0, 3'b001, 3'b001, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        DEC   = mk(0, 3'b010, 3'b001, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        RWB   = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        IEX   = mk(1, 3'b011, 3'b001, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        IWB   = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        MR1   = mk(0, 3'b000, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        MR2   = mk(0, 3'b000, 3'b000, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        MEX   = mk(1, 3'b100, 3'b001, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        BEQ_T = mk(1, 3'b000, 3'b010, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        BEQ_N = mk(1, 3'b000, 3'b010, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        ILL   = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // sub, add, and
        push_front(6'h00, 6'h22);
        push(6'h00, 6'h22, 1, mk(1, 3'b000, 3'b010, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        push(6'h00, 6'h22, 1, RWB);
        push_front(6'h00, 6'h20);
        push(6'h00, 6'h20, 1, mk(1, 3'b000, 3'b001, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        push(6'h00, 6'h20, 1, RWB);
        push_front(6'h00, 6'h24);
        push(6'h00, 6'h24, 1, mk(1, 3'b000, 3'b011, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        push(6'h00, 6'h24, 1, RWB);
        // addi
        push_front(6'h08, 6'h00);
        push(6'h08, 6'h00, 1, IEX);
        push(6'h08, 6'h00, 1, IWB);
        // addm
        push_front(6'h00, 6'h05);
        push(6'h00, 6'h05, 1, MR1);
        push(6'h00, 6'h05, 1, MR2);
        push(6'h00, 6'h05, 1, MEX);
        push(6'h00, 6'h05, 1, RWB);
        // beq taken / not taken
        push_front(6'h04, 6'h00);
        push(6'h04, 6'h00, 1, BEQ_T);
        push_front(6'h04, 6'h00);
        push(6'h04, 6'h00, 0, BEQ_N);
        // illegal opcode, then illegal funct under opcode 0
        push_front(6'h3F, 6'h00);
        push(6'h3F, 6'h00, 1, ILL);
        push_front(6'h00, 6'h21);
        push(6'h00, 6'h21, 1, ILL);
        push(6'h00, 6'h21, 1, F1);

        reset  = 1'b1;
        opcode = 6'h00;
        funct  = 6'h00;
        zero   = 1'b1;
        for (int i = 0; i < 3; i++) step("reset_hold", 6'h00, 6'h00, 1'b1, ZERO);
        reset = 1'b0;

        for (int i = 0; i < nvec; i++)
            step($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].exp);

        // Reset asserted during M_EXEC: outputs must drop inside the same cycle.
        step("mr_f2", 6'h00, 6'h05, 1, F2);
        step("mr_dec", 6'h00, 6'h05, 1, DEC);
        step("mr_rd1", 6'h00, 6'h05, 1, MR1);
        step("mr_rd2", 6'h00, 6'h05, 1, MR2);
        step("mr_mexec", 6'h00, 6'h05, 1, MEX);
        #1 reset = 1'b1;
        #1 check("mr_async_drop", ZERO);
        step("mr_held", 6'h00, 6'h05, 1, ZERO);
        reset = 1'b0;
        step("mr_restart_f1", 6'h00, 6'h05, 1, F1);
        step("mr_restart_f2", 6'h00, 6'h05, 1, F2);
        step("mr_restart_dec", 6'h00, 6'h05, 1, DEC);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end
endmodule
